// File: rtl/demux_n_to_wide.sv
// Narrow-to-wide lane assembler: packs RATIO valid beats of IN_W bits into one word,
// with gap tolerance on valid and a flush that emits a partial word plus lane enables.
module demux_n_to_wide #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  valid,
    input  logic                  flush,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic                  valid_out,
    output logic [RATIO-1:0]      lane_en,
    output logic                  partial
);

    localparam int             OW       = IN_W * RATIO;
    localparam int             CW       = $clog2(RATIO + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(RATIO - 1);

    logic [OW-1:0]    r_acc;
    logic [RATIO-1:0] r_mask;
    logic [CW-1:0]    r_cnt;
    logic [OW-1:0]    r_data_out;
    logic             r_valid_out;
    logic [RATIO-1:0] r_lane_en;
    logic             r_partial;

    logic [CW-1:0]    w_lane;
    logic [OW-1:0]    w_acc_ins;
    logic [RATIO-1:0] w_mask_ins;
    logic [CW-1:0]    w_cnt_next;
    logic             w_full;
    logic             w_flush_emit;

    // Accumulator and mask with the current beat inserted, plus the emission decisions.
    always_comb begin
        w_lane     = (MSB_FIRST != 0) ? CW'(LAST_IDX - r_cnt) : r_cnt;
        w_acc_ins  = r_acc;
        w_mask_ins = r_mask;
        for (int i = 0; i < RATIO; i++) begin
            w_acc_ins[i*IN_W +: IN_W] = (valid && (w_lane == CW'(i))) ? data_in
                                                                       : r_acc[i*IN_W +: IN_W];
            w_mask_ins[i]             = (valid && (w_lane == CW'(i))) ? 1'b1 : r_mask[i];
        end
        w_full       = valid && (r_cnt == LAST_IDX);
        // A beat completing the word takes priority; the flush then has nothing left.
        w_flush_emit = flush && !w_full && (valid || (r_cnt != {CW{1'b0}}));
        w_cnt_next   = r_cnt + {{(CW-1){1'b0}}, valid};
    end

    // Assembly state: beat counter, accumulator and lane-fill mask.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_acc  <= {OW{1'b0}};
            r_mask <= {RATIO{1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else if (w_full || w_flush_emit) begin
            r_acc  <= {OW{1'b0}};
            r_mask <= {RATIO{1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else begin
            r_acc  <= w_acc_ins;
            r_mask <= w_mask_ins;
            r_cnt  <= w_cnt_next;
        end
    end

    // Output register stage; word, lane enables and partial flag hold between emissions.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_data_out  <= {OW{1'b0}};
            r_valid_out <= 1'b0;
            r_lane_en   <= {RATIO{1'b0}};
            r_partial   <= 1'b0;
        end else if (w_full) begin
            r_data_out  <= w_acc_ins;
            r_valid_out <= 1'b1;
            r_lane_en   <= {RATIO{1'b1}};
            r_partial   <= 1'b0;
        end else if (w_flush_emit) begin
            r_data_out  <= w_acc_ins;
            r_valid_out <= 1'b1;
            r_lane_en   <= w_mask_ins;
            r_partial   <= 1'b1;
        end else begin
            r_valid_out <= 1'b0;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign lane_en   = r_lane_en;
    assign partial   = r_partial;

endmodule

// File: tb/tb_demux_n_to_wide.sv
// Directed bench for demux_n_to_wide: default MSB-first, LSB-first, and a 4-bit x 8 variant
// exercising reset mid-word. Inputs driven and outputs sampled on the falling edge.
module tb_demux_n_to_wide;

    logic clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    int n_checks = 0;
    int n_errors = 0;

    // DUT A: defaults (IN_W=8, RATIO=4, MSB_FIRST=1)
    logic        a_rst, a_v, a_f, a_vo, a_part;
    logic [7:0]  a_din;
    logic [31:0] a_dout;
    logic [3:0]  a_len;

    // DUT B: LSB-first
    logic        b_rst, b_v, b_f, b_vo, b_part;
    logic [7:0]  b_din;
    logic [31:0] b_dout;
    logic [3:0]  b_len;

    // DUT C: IN_W=4, RATIO=8
    logic        c_rst, c_v, c_f, c_vo, c_part;
    logic [3:0]  c_din;
    logic [31:0] c_dout;
    logic [7:0]  c_len;

    demux_n_to_wide u_dut_a (
        .clk_4f(clk_4f), .reset(a_rst), .data_in(a_din), .valid(a_v), .flush(a_f),
        .data_out(a_dout), .valid_out(a_vo), .lane_en(a_len), .partial(a_part)
    );

    demux_n_to_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_dut_b (
        .clk_4f(clk_4f), .reset(b_rst), .data_in(b_din), .valid(b_v), .flush(b_f),
        .data_out(b_dout), .valid_out(b_vo), .lane_en(b_len), .partial(b_part)
    );

    demux_n_to_wide #(.IN_W(4), .RATIO(8), .MSB_FIRST(1)) u_dut_c (
        .clk_4f(clk_4f), .reset(c_rst), .data_in(c_din), .valid(c_v), .flush(c_f),
        .data_out(c_dout), .valid_out(c_vo), .lane_en(c_len), .partial(c_part)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Each step presents inputs at a falling edge; the next falling edge sees the result.
    task automatic step_a(input logic [7:0] d, input logic v, input logic f);
        a_din = d; a_v = v; a_f = f;
        @(negedge clk_4f);
    endtask

    task automatic step_b(input logic [7:0] d, input logic v, input logic f);
        b_din = d; b_v = v; b_f = f;
        @(negedge clk_4f);
    endtask

    task automatic step_c(input logic [3:0] d, input logic v, input logic f);
        c_din = d; c_v = v; c_f = f;
        @(negedge clk_4f);
    endtask

    initial begin
        a_rst = 1'b0; a_v = 1'b0; a_f = 1'b0; a_din = 8'h00;
        b_rst = 1'b0; b_v = 1'b0; b_f = 1'b0; b_din = 8'h00;
        c_rst = 1'b0; c_v = 1'b0; c_f = 1'b0; c_din = 4'h0;
        @(negedge clk_4f);
        check_val("rst_a_dout", 64'(a_dout), 64'h0);
        check_val("rst_a_vo",   64'(a_vo),   64'h0);
        check_val("rst_a_len",  64'(a_len),  64'h0);
        check_val("rst_a_part", 64'(a_part), 64'h0);
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;

        // Full word, consecutive beats
        step_a(8'hEE, 1'b1, 1'b0); check_val("t1_vo_b0", 64'(a_vo), 64'h0);
        step_a(8'hFF, 1'b1, 1'b0); check_val("t1_vo_b1", 64'(a_vo), 64'h0);
        step_a(8'hFD, 1'b1, 1'b0); check_val("t1_vo_b2", 64'(a_vo), 64'h0);
        step_a(8'hCC, 1'b1, 1'b0);
        check_val("t1_vo",   64'(a_vo),   64'h1);
        check_val("t1_dout", 64'(a_dout), 64'hEEFFFDCC);
        check_val("t1_len",  64'(a_len),  64'hF);
        check_val("t1_part", 64'(a_part), 64'h0);
        step_a(8'h00, 1'b0, 1'b0);
        check_val("t1_vo_after", 64'(a_vo),   64'h0);
        check_val("t1_hold",     64'(a_dout), 64'hEEFFFDCC);

        // Gap of two idle cycles between FF and FD
        step_a(8'hEE, 1'b1, 1'b0);
        step_a(8'hFF, 1'b1, 1'b0);
        step_a(8'h55, 1'b0, 1'b0); check_val("t2_vo_gap0", 64'(a_vo), 64'h0);
        step_a(8'h55, 1'b0, 1'b0); check_val("t2_vo_gap1", 64'(a_vo), 64'h0);
        step_a(8'hFD, 1'b1, 1'b0); check_val("t2_vo_b2",   64'(a_vo), 64'h0);
        step_a(8'hCC, 1'b1, 1'b0);
        check_val("t2_vo",   64'(a_vo),   64'h1);
        check_val("t2_dout", 64'(a_dout), 64'hEEFFFDCC);
        step_a(8'h00, 1'b0, 1'b0); check_val("t2_vo_after", 64'(a_vo), 64'h0);

        // Flush alone after two beats
        step_a(8'hAA, 1'b1, 1'b0);
        step_a(8'h12, 1'b1, 1'b0);
        step_a(8'h00, 1'b0, 1'b1);
        check_val("t3_vo",   64'(a_vo),   64'h1);
        check_val("t3_dout", 64'(a_dout), 64'hAA120000);
        check_val("t3_len",  64'(a_len),  64'hC);
        check_val("t3_part", 64'(a_part), 64'h1);
        step_a(8'h00, 1'b0, 1'b0); check_val("t3_vo_after", 64'(a_vo), 64'h0);
        step_a(8'h00, 1'b0, 1'b1);
        check_val("t3_empty_flush_vo", 64'(a_vo),   64'h0);
        check_val("t3_empty_hold",     64'(a_dout), 64'hAA120000);
        check_val("t3_empty_part",     64'(a_part), 64'h1);

        // Flush on the completing beat gives a single full emission
        step_a(8'hEE, 1'b1, 1'b0);
        step_a(8'hFF, 1'b1, 1'b0);
        step_a(8'hFD, 1'b1, 1'b0);
        step_a(8'hCC, 1'b1, 1'b1);
        check_val("t5_vo",   64'(a_vo),   64'h1);
        check_val("t5_dout", 64'(a_dout), 64'hEEFFFDCC);
        check_val("t5_len",  64'(a_len),  64'hF);
        check_val("t5_part", 64'(a_part), 64'h0);
        step_a(8'h00, 1'b0, 1'b0); check_val("t5_no_second", 64'(a_vo), 64'h0);

        // LSB-first ordering, then valid+flush on the second beat
        step_b(8'hEE, 1'b1, 1'b0);
        step_b(8'hFF, 1'b1, 1'b0);
        step_b(8'hFD, 1'b1, 1'b0);
        step_b(8'hCC, 1'b1, 1'b0);
        check_val("t4_vo",   64'(b_vo),   64'h1);
        check_val("t4_dout", 64'(b_dout), 64'hCCFDFFEE);
        step_b(8'h12, 1'b1, 1'b0); check_val("t4_vo_b0", 64'(b_vo), 64'h0);
        step_b(8'hBB, 1'b1, 1'b1);
        check_val("t4_flush_vo",   64'(b_vo),   64'h1);
        check_val("t4_flush_dout", 64'(b_dout), 64'h0000BB12);
        check_val("t4_flush_len",  64'(b_len),  64'h3);
        check_val("t4_flush_part", 64'(b_part), 64'h1);

        // 4-bit x 8: full word, then reset mid-word, then clean word
        for (int k = 1; k <= 8; k++) step_c(4'(k), 1'b1, 1'b0);
        check_val("t6_pre_vo",   64'(c_vo),   64'h1);
        check_val("t6_pre_dout", 64'(c_dout), 64'h12345678);
        for (int k = 1; k <= 5; k++) step_c(4'(k), 1'b1, 1'b0);
        c_v = 1'b0;
        #1 c_rst = 1'b0;
        #1;
        check_val("t6_rst_dout", 64'(c_dout), 64'h0);
        check_val("t6_rst_vo",   64'(c_vo),   64'h0);
        check_val("t6_rst_len",  64'(c_len),  64'h0);
        check_val("t6_rst_part", 64'(c_part), 64'h0);
        @(negedge clk_4f);
        c_rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step_c(4'(k), 1'b1, 1'b0);
            check_val($sformatf("t6_vo_b%0d", k), 64'(c_vo), 64'h0);
        end
        step_c(4'h8, 1'b1, 1'b0);
        check_val("t6_vo",   64'(c_vo),   64'h1);
        check_val("t6_dout", 64'(c_dout), 64'h12345678);
        check_val("t6_len",  64'(c_len),  64'hFF);
        step_c(4'h0, 1'b0, 1'b0); check_val("t6_vo_after", 64'(c_vo), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
